// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module : fifo_pkg
// Purpose: Shared helpers for the dual-clock FIFO read and write controllers:
//          Gray/binary pointer conversion, pointer-width helper and
//          legal-range checks for the controller parameters.
// Ports  : none (package)
// Rev    : 1.0  initial parametrised release
// ============================================================================
package fifo_pkg;

  // Conversion functions work on a fixed maximum width. Callers zero-extend
  // their pointer into it and truncate the result. Zero upper bits pass
  // through both conversions unchanged, so the narrow result is exact.
  localparam int c_ptr_max_w       = 16;
  localparam int c_addr_w_min      = 2;
  localparam int c_addr_w_max      = 12;
  localparam int c_sync_stages_min = 2;
  localparam int c_sync_stages_max = 4;

  // The extra MSB separates a full FIFO from an empty one.
  function automatic int ptr_w(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic bit addr_w_legal(input int addr_w);
    return (addr_w >= c_addr_w_min) && (addr_w <= c_addr_w_max);
  endfunction

  function automatic bit sync_stages_legal(input int stages);
    return (stages >= c_sync_stages_min) && (stages <= c_sync_stages_max);
  endfunction

  function automatic logic [c_ptr_max_w-1:0] bin2gray(input logic [c_ptr_max_w-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [c_ptr_max_w-1:0] gray2bin(input logic [c_ptr_max_w-1:0] gray);
    logic [c_ptr_max_w-1:0] bin;
    bin[c_ptr_max_w-1] = gray[c_ptr_max_w-1];
    for (int i = c_ptr_max_w - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ptr_sync.sv
`default_nettype none
// ============================================================================
// Module : ptr_sync
// Purpose: Multi-flop synchroniser for a Gray-coded pointer that crosses
//          clock domains. It is a plain flop chain with no logic between
//          stages, so every stage has the whole period to settle.
// Ports  : clk      destination-domain clock
//          reset_n  asynchronous active-low reset, clears every stage
//          d        pointer from the source domain
//          q        synchronised pointer (STAGES edges of latency)
// Rev    : 1.0  initial release
// ============================================================================
module ptr_sync #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_sync [STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/async_fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module : async_fifo_rd_ctrl
// Purpose: Read-domain controller of the dual-clock FIFO. It owns the binary
//          and Gray read pointers, synchronises the write Gray pointer and
//          derives the registered empty, almost-empty, fill-level and sticky
//          underflow flags.
// Ports  : clk              read-domain clock
//          reset_n          asynchronous active-low reset
//          rd_en            read request from the consumer
//          wr_ptr_gray      write pointer, Gray, from the write domain
//          ae_thresh        almost-empty threshold (quasi-static)
//          underflow_clr    one-cycle pulse, clears rd_underflow
//          rd_addr          RAM read address (registered)
//          rd_ptr_gray      Gray read pointer to the write domain (registered)
//          rd_empty         FIFO empty (registered)
//          rd_almost_empty  rd_level <= ae_thresh (registered)
//          rd_level         words available as seen from the read side
//          rd_underflow     sticky: a read was attempted while empty
// Rev    : 1.0  parametrised successor of the basic read-pointer block
// ============================================================================
module async_fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AE_RESET    = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd_en,
  input  logic [ADDR_W:0]   wr_ptr_gray,
  input  logic [ADDR_W:0]   ae_thresh,
  input  logic              underflow_clr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   rd_ptr_gray,
  output logic              rd_empty,
  output logic              rd_almost_empty,
  output logic [ADDR_W:0]   rd_level,
  output logic              rd_underflow
);

  localparam int c_ptr_w = ptr_w(ADDR_W);

  // Elaboration-time parameter checks; AE_RESET only documents the usual
  // threshold, so it is merely range-checked here.
  generate
    if (!addr_w_legal(ADDR_W)) begin : g_bad_addr_w
      $error("async_fifo_rd_ctrl: ADDR_W out of range 2..12");
    end
    if (!sync_stages_legal(SYNC_STAGES)) begin : g_bad_sync_stages
      $error("async_fifo_rd_ctrl: SYNC_STAGES out of range 2..4");
    end
    if ((AE_RESET < 0) || (AE_RESET > (1 << ADDR_W))) begin : g_bad_ae_reset
      $error("async_fifo_rd_ctrl: AE_RESET outside 0..depth");
    end
  endgenerate

  logic [c_ptr_w-1:0] r_rd_bin;
  logic [c_ptr_w-1:0] r_rd_gray;
  logic [c_ptr_w-1:0] r_rd_level;
  logic               r_rd_empty;
  logic               r_rd_almost_empty;
  logic               r_rd_underflow;

  logic               w_rd_accept;
  logic [c_ptr_w-1:0] w_rd_bin_next;
  logic [c_ptr_w-1:0] w_rd_gray_next;
  logic [c_ptr_w-1:0] w_wr_gray_s;
  logic [c_ptr_w-1:0] w_wr_bin_s;
  logic [c_ptr_w-1:0] w_level_next;

  ptr_sync #(
    .WIDTH  (c_ptr_w),
    .STAGES (SYNC_STAGES)
  ) u_wr_ptr_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (wr_ptr_gray),
    .q       (w_wr_gray_s)
  );

  // Reads are gated by the registered empty flag, so the pointer can never
  // advance past the last synchronised write.
  assign w_rd_accept    = rd_en & ~r_rd_empty;
  assign w_rd_bin_next  = r_rd_bin + {{(c_ptr_w-1){1'b0}}, w_rd_accept};
  assign w_rd_gray_next = c_ptr_w'(bin2gray(c_ptr_max_w'(w_rd_bin_next)));
  assign w_wr_bin_s     = c_ptr_w'(gray2bin(c_ptr_max_w'(w_wr_gray_s)));

  // Modulo 2**(ADDR_W+1) difference; a stale write pointer can only make
  // this smaller than the true fill, never larger.
  assign w_level_next   = w_wr_bin_s - w_rd_bin_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_bin          <= '0;
      r_rd_gray         <= '0;
      r_rd_level        <= '0;
      r_rd_empty        <= 1'b1;
      r_rd_almost_empty <= 1'b1;
    end else begin
      r_rd_bin          <= w_rd_bin_next;
      r_rd_gray         <= w_rd_gray_next;
      r_rd_level        <= w_level_next;
      // Compare against the next pointer so empty rises on the same edge
      // as the read that takes the last word.
      r_rd_empty        <= (w_rd_gray_next == w_wr_gray_s);
      r_rd_almost_empty <= (w_level_next <= ae_thresh);
    end
  end

  // Set has priority over clear, so an underflow coinciding with a clear
  // pulse is not lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_underflow <= 1'b0;
    end else if (rd_en && r_rd_empty) begin
      r_rd_underflow <= 1'b1;
    end else if (underflow_clr) begin
      r_rd_underflow <= 1'b0;
    end
  end

  assign rd_addr         = r_rd_bin[ADDR_W-1:0];
  assign rd_ptr_gray     = r_rd_gray;
  assign rd_empty        = r_rd_empty;
  assign rd_almost_empty = r_rd_almost_empty;
  assign rd_level        = r_rd_level;
  assign rd_underflow    = r_rd_underflow;

endmodule
`default_nettype wire

// File: tb/tb_async_fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_async_fifo_rd_ctrl
// Purpose: Directed self-checking bench for async_fifo_rd_ctrl with
//          ADDR_W = 4 and SYNC_STAGES = 2.
// Rev    : 1.0  initial release
// ============================================================================
module tb_async_fifo_rd_ctrl;

  localparam int ADDR_W      = 4;
  localparam int SYNC_STAGES = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              rd_en;
  logic [ADDR_W:0]   wr_ptr_gray;
  logic [ADDR_W:0]   ae_thresh;
  logic              underflow_clr;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W:0]   rd_ptr_gray;
  logic              rd_empty;
  logic              rd_almost_empty;
  logic [ADDR_W:0]   rd_level;
  logic              rd_underflow;

  int n_vec = 0;
  int n_err = 0;

  logic [ADDR_W:0] tb_rd_bin;
  logic [ADDR_W:0] tb_wr_bin;
  int              exp_level;

  async_fifo_rd_ctrl #(
    .ADDR_W      (ADDR_W),
    .SYNC_STAGES (SYNC_STAGES),
    .AE_RESET    (1)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .rd_en           (rd_en),
    .wr_ptr_gray     (wr_ptr_gray),
    .ae_thresh       (ae_thresh),
    .underflow_clr   (underflow_clr),
    .rd_addr         (rd_addr),
    .rd_ptr_gray     (rd_ptr_gray),
    .rd_empty        (rd_empty),
    .rd_almost_empty (rd_almost_empty),
    .rd_level        (rd_level),
    .rd_underflow    (rd_underflow)
  );

  always #5 clk = ~clk;

  function automatic logic [ADDR_W:0] to_gray(input logic [ADDR_W:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock edge and sample 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " empty"},  32'(rd_empty), 32'd1);
    check({tag, " ae"},     32'(rd_almost_empty), 32'd1);
    check({tag, " level"},  32'(rd_level), 32'd0);
    check({tag, " addr"},   32'(rd_addr), 32'd0);
    check({tag, " gray"},   32'(rd_ptr_gray), 32'd0);
    check({tag, " uf"},     32'(rd_underflow), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n       = 1'b0;
    rd_en         = 1'b1;
    wr_ptr_gray   = '0;
    ae_thresh     = '0;
    underflow_clr = 1'b0;
    tb_rd_bin     = '0;
    tb_wr_bin     = '0;

    // 1. Reset held with rd_en high.
    repeat (3) step();
    check_reset_values("reset");
    reset_n = 1'b1;
    rd_en   = 1'b0;
    step();

    // 2. Single word: empty falls exactly three edges after the write.
    tb_wr_bin   = 5'd1;
    wr_ptr_gray = to_gray(tb_wr_bin);
    step();
    check("single edge1 empty", 32'(rd_empty), 32'd1);
    step();
    check("single edge2 empty", 32'(rd_empty), 32'd1);
    step();
    check("single edge3 empty", 32'(rd_empty), 32'd0);
    check("single level", 32'(rd_level), 32'd1);
    check("single ae thr0", 32'(rd_almost_empty), 32'd0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    tb_rd_bin = 5'd1;
    check("single rd addr", 32'(rd_addr), 32'd1);
    check("single rd gray", 32'(rd_ptr_gray), 32'b00001);
    check("single rd empty", 32'(rd_empty), 32'd1);
    check("single rd level", 32'(rd_level), 32'd0);
    check("single rd ae thr0", 32'(rd_almost_empty), 32'd1);

    // 3/4. Full fill and drain for three laps with ae_thresh = 3.
    ae_thresh = 5'd3;
    for (int lap = 0; lap < 3; lap++) begin
      tb_wr_bin   = tb_wr_bin + 5'd16;
      wr_ptr_gray = to_gray(tb_wr_bin);
      repeat (SYNC_STAGES + 1) step();
      check("lap full level", 32'(rd_level), 32'd16);
      check("lap full empty", 32'(rd_empty), 32'd0);
      check("lap full ae", 32'(rd_almost_empty), 32'd0);
      rd_en = 1'b1;
      for (int k = 1; k <= 16; k++) begin
        step();
        tb_rd_bin = tb_rd_bin + 5'd1;
        exp_level = 16 - k;
        check("drain level", 32'(rd_level), 32'(exp_level));
        check("drain gray", 32'(rd_ptr_gray), 32'(to_gray(tb_rd_bin)));
        check("drain addr", 32'(rd_addr), 32'(tb_rd_bin[ADDR_W-1:0]));
        check("drain empty", 32'(rd_empty), (k == 16) ? 32'd1 : 32'd0);
        check("drain ae", 32'(rd_almost_empty), (exp_level <= 3) ? 32'd1 : 32'd0);
      end
      rd_en = 1'b0;
    end

    // 5. Underflow: set, set-beats-clear, then clear alone.
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("uf set", 32'(rd_underflow), 32'd1);
    check("uf addr hold", 32'(rd_addr), 32'(tb_rd_bin[ADDR_W-1:0]));
    check("uf gray hold", 32'(rd_ptr_gray), 32'(to_gray(tb_rd_bin)));
    rd_en         = 1'b1;
    underflow_clr = 1'b1;
    step();
    rd_en         = 1'b0;
    check("uf set wins", 32'(rd_underflow), 32'd1);
    step();
    underflow_clr = 1'b0;
    check("uf clr", 32'(rd_underflow), 32'd0);

    // Threshold at or above depth forces almost-empty.
    tb_wr_bin   = tb_wr_bin + 5'd9;
    wr_ptr_gray = to_gray(tb_wr_bin);
    repeat (SYNC_STAGES + 1) step();
    check("mid level 9", 32'(rd_level), 32'd9);
    ae_thresh = 5'd16;
    step();
    check("ae thr depth", 32'(rd_almost_empty), 32'd1);
    ae_thresh = 5'd8;
    step();
    check("ae thr 8 lvl 9", 32'(rd_almost_empty), 32'd0);

    // 6. Reset mid-operation with reads in flight.
    rd_en = 1'b1;
    step();
    check("mid read level", 32'(rd_level), 32'd8);
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_values("async reset");
    wr_ptr_gray = '0;
    rd_en       = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post reset empty", 32'(rd_empty), 32'd1);
      check("post reset level", 32'(rd_level), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
